// File: rtl/uart_rx_scheduler.sv
// uart_rx_scheduler
//   Time-slot scheduler sharing one clock domain between the game FSM and the UART
//   receiver. The game is paused through a registered clock-enable (game_en) for a
//   fixed window after each UART start bit. A byte received in the meantime is
//   buffered and handed to the game over valid/ready once the window closes.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   rx_line      raw serial line (asynchronous, idle high)
//   rx_valid     one-cycle pulse: rx_data holds a received byte
//   rx_data      received byte
//   byte_ready   game accepts byte_data this cycle
//   clr_overrun  clears the sticky overrun flag
//   game_en      clock enable for the game logic
//   byte_valid   byte_data holds an undelivered byte
//   byte_data    buffered byte
//   overrun      sticky: a received byte was dropped
//   hold_active  high while the game is paused
module uart_rx_scheduler #(
  parameter int unsigned SETUP_CYCLES = 10_000_000,
  parameter int unsigned HOLD_CYCLES  = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       byte_ready,
  input  logic       clr_overrun,
  output logic       game_en,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       overrun,
  output logic       hold_active
);

  localparam int unsigned SetupW = $clog2(SETUP_CYCLES + 1);
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);

  localparam logic [SetupW-1:0] SetupLast = SetupW'(SETUP_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StStartup,
    StRun,
    StHold,
    StDeliver
  } state_e;

  state_e            state_q, state_d;
  logic [SetupW-1:0] setup_cnt_q, setup_cnt_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              pending_q, pending_d;
  logic              defer_q, defer_d;
  logic [7:0]        byte_data_d;
  logic              overrun_d;

  // rx_line synchronizer plus one history flop for falling-edge detection.
  logic sync1_q, sync2_q, prev_q;
  logic start_edge;

  assign start_edge = !sync2_q && prev_q;

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    pending_d   = pending_q;
    defer_d     = defer_q;
    byte_data_d = byte_data;
    overrun_d   = overrun;

    unique case (state_q)
      StStartup: begin
        if (setup_cnt_q >= SetupLast) begin
          state_d = StRun;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (start_edge) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
          defer_d    = 1'b0;
        end
      end
      StHold: begin
        // Start edges seen here are ignored: the window never stretches.
        if (hold_cnt_q == '0) begin
          state_d = pending_q ? StDeliver : StRun;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      StDeliver: begin
        if (start_edge) begin
          defer_d = 1'b1;
        end
        if (byte_valid && byte_ready) begin
          pending_d = 1'b0;
          // A start edge arriving in the handshake cycle counts as deferred too.
          if (defer_q || start_edge) begin
            state_d    = StHold;
            hold_cnt_d = HoldLoad;
            defer_d    = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StStartup;
    endcase

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    // Single-entry buffer; a set of overrun overrides a same-cycle clear.
    if (rx_valid && (state_q != StStartup)) begin
      if ((state_q == StDeliver) || pending_q) begin
        overrun_d = 1'b1;
      end else begin
        byte_data_d = rx_data;
        pending_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= StStartup;
      setup_cnt_q <= '0;
      hold_cnt_q  <= '0;
      pending_q   <= 1'b0;
      defer_q     <= 1'b0;
      byte_data   <= '0;
      overrun     <= 1'b0;
      game_en     <= 1'b0;
      byte_valid  <= 1'b0;
      hold_active <= 1'b0;
    end else begin
      sync1_q     <= rx_line;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      pending_q   <= pending_d;
      defer_q     <= defer_d;
      byte_data   <= byte_data_d;
      overrun     <= overrun_d;
      // Decoded from the next state so outputs switch on the same edge as the state.
      game_en     <= (state_d != StHold);
      byte_valid  <= (state_d == StDeliver);
      hold_active <= (state_d == StHold);
    end
  end

endmodule

// File: tb/tb_uart_rx_scheduler.sv
module tb_uart_rx_scheduler;

  localparam int unsigned SETUP = 8;
  localparam int unsigned HOLD  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       byte_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       game_en;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       overrun;
  logic       hold_active;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected delivered bytes and expected game_en low-window lengths.
  logic [7:0] byte_q[$];
  int         hold_q[$];

  uart_rx_scheduler #(
    .SETUP_CYCLES(SETUP),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_line    (rx_line),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .byte_ready (byte_ready),
    .clr_overrun(clr_overrun),
    .game_en    (game_en),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .overrun    (overrun),
    .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: measures every game_en low window and checks each presented byte.
  initial begin : monitor
    int         low_run;
    bit         counting;
    logic       prev_ge;
    logic       prev_bv;
    logic [7:0] shown;
    int         exp_len;
    logic [7:0] exp_byte;
    low_run  = 0;
    counting = 1'b0;
    prev_ge  = 1'b0;
    prev_bv  = 1'b0;
    shown    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_run  = 0;
        counting = 1'b0;
        prev_ge  = 1'b0;
        prev_bv  = 1'b0;
      end else begin
        if (!game_en) begin
          if (prev_ge) begin
            counting = 1'b1;
            low_run  = 0;
          end
          if (counting) low_run++;
        end else if (counting) begin
          counting = 1'b0;
          if (hold_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL hold_window: got unexpected pause of %0d cycles, required none", low_run);
          end else begin
            exp_len = hold_q.pop_front();
            chk("hold_window_len", low_run, exp_len);
          end
        end

        if (byte_valid && !prev_bv) begin
          shown = byte_data;
          if (byte_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL byte_present: got unexpected byte %0h, required none", byte_data);
          end else begin
            exp_byte = byte_q.pop_front();
            chk("byte_present_data", byte_data, exp_byte);
          end
          chk("game_en_on_present", game_en, 1);
        end else if (byte_valid) begin
          chk("byte_data_stable", byte_data, shown);
          chk("game_en_in_deliver", game_en, 1);
        end
        prev_ge = game_en;
        prev_bv = byte_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit found;

    // 1. Reset state, then STARTUP ignores rx_line toggles and rx_valid.
    steps(3);
    sample();
    chk("rst_game_en", game_en, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_hold_active", hold_active, 0);
    step();
    rst = 1'b0;  // released after edge 0
    for (int i = 1; i <= 12; i++) begin
      step();
      rx_line  = (i > 4) || (i % 2 == 1);
      rx_valid = (i == 3);
      rx_data  = (i == 3) ? 8'h77 : 8'h00;
      sample();
      chk("t1_game_en", game_en, 1);
      chk("t1_hold_active", hold_active, 0);
    end

    // 2. Start edge in RUN without a byte: 20-cycle pause, no delivery.
    hold_q.push_back(HOLD);
    step();
    rx_line = 1'b0;  // falls before edge k
    steps(2);        // edges k, k+1
    sample();
    chk("t2_game_en_k1", game_en, 1);
    step();          // edge k+2
    rx_line = 1'b1;
    sample();
    chk("t2_game_en_k2", game_en, 0);
    chk("t2_hold_active", hold_active, 1);
    steps(24);
    sample();
    chk("t2_game_en_after", game_en, 1);
    chk("t2_hold_after", hold_active, 0);
    chk("t2_byte_valid", byte_valid, 0);

    // 3. Byte mid-HOLD, game stalls byte_ready for 5 cycles.
    hold_q.push_back(HOLD);
    byte_q.push_back(8'hA5);
    byte_ready = 1'b0;
    step();
    rx_line = 1'b0;
    steps(3);
    rx_line = 1'b1;
    steps(7);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (byte_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_deliver_reached", found, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      sample();
      chk("t3_byte_valid_wait", byte_valid, 1);
      chk("t3_byte_data_wait", byte_data, 8'hA5);
    end
    step();
    byte_ready = 1'b1;
    sample();
    step();          // handshake edge
    byte_ready = 1'b0;
    sample();
    chk("t3_byte_valid_after", byte_valid, 0);
    chk("t3_game_en_after", game_en, 1);

    // 4. Two bytes in one HOLD: first kept, overrun sticky; set beats clear.
    hold_q.push_back(HOLD);
    byte_q.push_back(8'h11);
    byte_ready = 1'b1;
    step();
    rx_line = 1'b0;
    steps(3);
    rx_line = 1'b1;
    steps(7);
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    step();
    rx_valid = 1'b0;
    step();
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    step();
    rx_valid = 1'b0;
    sample();
    chk("t4_overrun_set", overrun, 1);
    chk("t4_hold_active", hold_active, 1);
    step();
    rx_valid    = 1'b1;
    rx_data     = 8'h33;
    clr_overrun = 1'b1;
    step();
    rx_valid    = 1'b0;
    clr_overrun = 1'b0;
    sample();
    chk("t4_set_beats_clear", overrun, 1);
    steps(20);
    sample();
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_byte_valid_done", byte_valid, 0);
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    sample();
    chk("t4_overrun_cleared", overrun, 0);

    // 5. Start edge while waiting in DELIVER: direct DELIVER -> HOLD.
    hold_q.push_back(HOLD);
    hold_q.push_back(HOLD);
    byte_q.push_back(8'h5A);
    byte_ready = 1'b0;
    step();
    rx_line = 1'b0;
    steps(3);
    rx_line = 1'b1;
    steps(7);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    step();
    rx_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (byte_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_deliver_reached", found, 1);
    step();
    rx_line = 1'b0;  // before edge k
    steps(2);        // edges k, k+1
    sample();
    chk("t5_still_deliver", byte_valid, 1);
    step();          // edge k+2 latches the deferred start
    byte_ready = 1'b1;
    rx_line    = 1'b1;
    step();          // handshake edge
    byte_ready = 1'b0;
    sample();
    chk("t5_byte_valid_drop", byte_valid, 0);
    chk("t5_game_en_low", game_en, 0);
    chk("t5_hold_active", hold_active, 1);
    steps(25);
    sample();
    chk("t5_game_en_back", game_en, 1);
    chk("t5_byte_valid_idle", byte_valid, 0);

    // 6. Reset 7 cycles into HOLD with a byte pending: byte is lost.
    step();
    rx_line = 1'b0;
    steps(3);        // edge k+2: HOLD entered
    rx_line  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    step();
    rx_valid = 1'b0;
    steps(6);
    rst = 1'b1;
    #1;
    chk("t6_rst_game_en", game_en, 0);
    chk("t6_rst_byte_valid", byte_valid, 0);
    chk("t6_rst_hold_active", hold_active, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_byte_data", byte_data, 0);
    steps(2);
    rst = 1'b0;
    step();
    sample();
    chk("t6_startup_game_en", game_en, 1);
    chk("t6_startup_hold", hold_active, 0);
    steps(12);
    hold_q.push_back(HOLD);
    step();
    rx_line = 1'b0;
    steps(3);
    rx_line = 1'b1;
    steps(26);
    sample();
    chk("t6_game_en_final", game_en, 1);
    chk("t6_no_lost_byte", byte_valid, 0);

    chk("hold_queue_drained", hold_q.size(), 0);
    chk("byte_queue_drained", byte_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
